// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared definitions for the gate vector checker:
//   - reference function codes (FN_AND .. FN_XNOR) selected by GATE_FN
//   - the 2-bit sweep FSM state encoding
package gate_check_pkg;

  localparam int FN_AND  = 0;
  localparam int FN_OR   = 1;
  localparam int FN_NAND = 2;
  localparam int FN_NOR  = 3;
  localparam int FN_XOR  = 4;
  localparam int FN_XNOR = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model
// Combinational golden model of an N-input gate. It reduces the whole input
// vector with the function selected by GATE_FN.
// Parameters:
//   N_INPUTS  width of the input vector (1..6)
//   GATE_FN   function code from gate_check_pkg (FN_AND .. FN_XNOR)
// Ports:
//   vec    in   N_INPUTS  input vector applied to the gate
//   y_exp  out  1         expected gate output
module gate_ref_model
  import gate_check_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int GATE_FN  = FN_NAND
) (
  input  logic [N_INPUTS-1:0] vec,
  output logic                y_exp
);

  // An unknown function code produces a constant 0 reference.
  always_comb begin
    y_exp = 1'b0;
    case (GATE_FN)
      FN_AND:  y_exp = &vec;
      FN_OR:   y_exp = |vec;
      FN_NAND: y_exp = ~&vec;
      FN_NOR:  y_exp = ~|vec;
      FN_XOR:  y_exp = ^vec;
      FN_XNOR: y_exp = ~^vec;
      default: y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker
// Exhaustive stimulus/response checker for a combinational gate. It walks
// vec_out through every input combination from 0 to all-ones. Each vector is
// held for SETTLE cycles (DRIVE) and then sampled for one cycle (SAMPLE), where
// y_in is compared against gate_ref_model. When the sweep ends, the block reports
// the mismatch count, the first failing vector, and pass/fail.
// Parameters:
//   N_INPUTS  gate input width (1..6)
//   SETTLE    cycles each vector is held before sampling (>=1)
//   GATE_FN   reference function code (gate_check_pkg FN_*)
// Configuration macro:
//   GVC_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep
//                        immediately and vec_out holds the failing vector
// Ports:
//   clk             in   1           rising-edge clock
//   rst             in   1           asynchronous active-high reset
//   start           in   1           level-sampled sweep request (IDLE/DONE only)
//   y_in            in   1           output of the gate under test
//   vec_out         out  N_INPUTS    vector driven to the gate (bit 0 = input a)
//   busy            out  1           sweep in progress
//   done            out  1           sweep complete, results valid
//   pass            out  1           done with zero mismatches
//   err_count       out  N_INPUTS+1  number of mismatching vectors
//   fail_valid      out  1           at least one mismatch recorded
//   first_fail_vec  out  N_INPUTS    vector of the first mismatch
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int SETTLE   = 1,
  parameter int GATE_FN  = FN_NAND
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                y_in,
  output logic [N_INPUTS-1:0] vec_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] first_fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]       SETTLE_RELOAD = CW'(SETTLE - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST      = '1;
  localparam logic [N_INPUTS:0]   ERR_MAX       = {1'b1, {N_INPUTS{1'b0}}};

  state_t                state_q, state_d;
  logic [N_INPUTS-1:0]   vec_q, vec_d;
  logic [CW-1:0]         settle_q, settle_d;
  logic [N_INPUTS:0]     err_q, err_d;
  logic                  failValid_q, failValid_d;
  logic [N_INPUTS-1:0]   firstFail_q, firstFail_d;

  logic yExp;
  logic mismatch;
  logic stopOnFail;

  gate_ref_model #(
    .N_INPUTS (N_INPUTS),
    .GATE_FN  (GATE_FN)
  ) u_ref (
    .vec   (vec_q),
    .y_exp (yExp)
  );

  assign mismatch = (state_q == ST_SAMPLE) && (y_in != yExp);

`ifdef GVC_STOP_ON_FAIL_EN
  assign stopOnFail = mismatch;
`else
  assign stopOnFail = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      err_q       <= '0;
      failValid_q <= 1'b0;
      firstFail_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      failValid_q <= failValid_d;
      firstFail_q <= firstFail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    err_d       = err_q;
    failValid_d = failValid_q;
    firstFail_d = firstFail_q;

    case (state_q)
      // IDLE and DONE both accept a start request. DONE keeps its results
      // until a new sweep clears them.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_DRIVE;
          vec_d       = '0;
          settle_d    = SETTLE_RELOAD;
          err_d       = '0;
          failValid_d = 1'b0;
          firstFail_d = '0;
        end
      end

      ST_DRIVE: begin
        if (settle_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      // The error count cannot exceed 2^N_INPUTS in practice. The saturation
      // guard still keeps it from wrapping.
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!failValid_q) begin
            failValid_d = 1'b1;
            firstFail_d = vec_q;
          end
        end
        if (stopOnFail || (vec_q == VEC_LAST)) begin
          state_d = ST_DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = SETTLE_RELOAD;
          state_d  = ST_DRIVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign vec_out        = vec_q;
  assign busy           = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign fail_valid     = failValid_q;
  assign first_fail_vec = firstFail_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
// Scoreboard bench for gate_vector_checker. Two instances are used:
//   A: N_INPUTS=2, SETTLE=1, NAND
//   B: N_INPUTS=3, SETTLE=3, NAND
// The stimulus pushes the expected sweep result for each accepted start.
// A monitor per instance pops the result and compares it whenever done rises.
// The expected values depend on GVC_STOP_ON_FAIL_EN.
// The emulated gate under test (y_in) is chosen with a mode value:
//   0 correct NAND, 1 NOR (faulty), 2 stuck-at-0, 3 inverted NAND
module tb_gate_vector_checker;

  typedef struct {
    int err;
    int pass;
    int fv;
    int ffv;
    int lastVec;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic startA, startB;
  int   modeA, modeB;

  logic [1:0] vecA, ffA;
  logic [2:0] errA;
  logic       busyA, doneA, passA, fvA, yA;

  logic [2:0] vecB, ffB;
  logic [3:0] errB;
  logic       busyB, doneB, passB, fvB, yB;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t qA[$];
  exp_t qB[$];
  bit   prevBusy[2];
  bit   prevDone[2];
  int   startCycle[2];

  exp_t expANand, expANor, expBInv, expBStuck;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic gateOut(input int mode, input int vec, input int n);
    logic nandV;
    nandV = (vec != ((1 << n) - 1));
    case (mode)
      0:       return nandV;
      1:       return (vec == 0);
      2:       return 1'b0;
      default: return !nandV;
    endcase
  endfunction

  assign yA = gateOut(modeA, int'(vecA), 2);
  assign yB = gateOut(modeB, int'(vecB), 3);

  gate_vector_checker #(.N_INPUTS(2), .SETTLE(1), .GATE_FN(2)) dutA (
    .clk(clk), .rst(rst), .start(startA), .y_in(yA),
    .vec_out(vecA), .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .fail_valid(fvA), .first_fail_vec(ffA)
  );

  gate_vector_checker #(.N_INPUTS(3), .SETTLE(3), .GATE_FN(2)) dutB (
    .clk(clk), .rst(rst), .start(startB), .y_in(yB),
    .vec_out(vecB), .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .fail_valid(fvB), .first_fail_vec(ffB)
  );

  function automatic exp_t mkExp(input int err, pass, fv, ffv, lastVec, lat);
    exp_t e;
    e.err = err; e.pass = pass; e.fv = fv; e.ffv = ffv;
    e.lastVec = lastVec; e.lat = lat;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: latches the accept cycle on busy rising and scores the result on done rising.
  task automatic checkOutput(input int id, input logic busy, input logic done,
                             input logic pass, input logic fv,
                             input int err, input int ff, input int vec);
    exp_t  e;
    string tag;
    tag = (id == 0) ? "A" : "B";
    if (rst) begin
      prevBusy[id] = 1'b0;
      prevDone[id] = 1'b0;
      return;
    end
    if (busy && !prevBusy[id]) startCycle[id] = cycle;
    if (done && !prevDone[id]) begin
      if ((id == 0 && qA.size() == 0) || (id == 1 && qB.size() == 0)) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s unexpected_done: got done=1, expected no pending sweep", tag);
      end else begin
        e = (id == 0) ? qA.pop_front() : qB.pop_front();
        check({tag, " err_count"}, err, e.err);
        check({tag, " pass"}, int'(pass), e.pass);
        check({tag, " fail_valid"}, int'(fv), e.fv);
        check({tag, " first_fail_vec"}, ff, e.ffv);
        check({tag, " final vec_out"}, vec, e.lastVec);
        check({tag, " latency"}, cycle - startCycle[id] + 1, e.lat);
      end
    end
    prevBusy[id] = busy;
    prevDone[id] = done;
  endtask

  always @(negedge clk) begin
    checkOutput(0, busyA, doneA, passA, fvA, int'(errA), int'(ffA), int'(vecA));
    checkOutput(1, busyB, doneB, passB, fvB, int'(errB), int'(ffB), int'(vecB));
  end

  // Called at a negedge. Raises start for the next edge and returns at the negedge after acceptance.
  task automatic applyStimulus(input int id, input int mode, input exp_t e, input bit hold);
    if (id == 0) begin
      modeA = mode; qA.push_back(e); startA = 1'b1;
    end else begin
      modeB = mode; qB.push_back(e); startB = 1'b1;
    end
    @(negedge clk);
    if (!hold) begin
      if (id == 0) startA = 1'b0; else startB = 1'b0;
    end
  endtask

  task automatic waitDone(input int id, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((id == 0) ? doneA : doneB) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout id=%0d: got no done within %0d cycles, expected done", id, budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expANand  = mkExp(0, 1, 0, 0, 3, 9);
`ifdef GVC_STOP_ON_FAIL_EN
    expANor   = mkExp(1, 0, 1, 1, 1, 5);
    expBInv   = mkExp(1, 0, 1, 0, 0, 5);
    expBStuck = mkExp(1, 0, 1, 0, 0, 5);
`else
    expANor   = mkExp(2, 0, 1, 1, 3, 9);
    expBInv   = mkExp(8, 0, 1, 0, 7, 33);
    expBStuck = mkExp(7, 0, 1, 0, 7, 33);
`endif
    modeA = 0; modeB = 0;
    startA = 1'b0; startB = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    check("rst vec_out", int'(vecA), 0);
    check("rst busy", int'(busyA), 0);
    check("rst done", int'(doneA), 0);
    check("rst pass", int'(passA), 0);
    check("rst err_count", int'(errA), 0);
    check("rst fail_valid", int'(fvA), 0);
    check("rst B busy", int'(busyB), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: correct NAND, N=2");
    applyStimulus(0, 0, expANand, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("step%0d vec_out", k), int'(vecA), k / 2);
      check($sformatf("step%0d busy", k), int'(busyA), 1);
      @(negedge clk);
    end
    waitDone(0, 15);

    $display("[TB] test 2: NOR as faulty gate");
    applyStimulus(0, 1, expANor, 1'b0);
    waitDone(0, 15);

    $display("[TB] test 3: N=3 SETTLE=3, inverted NAND then stuck-at-0");
    applyStimulus(1, 3, expBInv, 1'b0);
    waitDone(1, 40);
    applyStimulus(1, 2, expBStuck, 1'b0);
    waitDone(1, 40);

    $display("[TB] test 4: reset mid-sweep");
    modeA = 0;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    for (int i = 0; i < 10 && vecA != 2'd2; i++) @(negedge clk);
    check("midsweep reached vec 2", int'(vecA), 2);
    #2 rst = 1'b1;
    #1;
    check("async rst vec_out", int'(vecA), 0);
    check("async rst busy", int'(busyA), 0);
    check("async rst done", int'(doneA), 0);
    check("async rst err_count", int'(errA), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst busy", int'(busyA), 0);
    applyStimulus(0, 0, expANand, 1'b0);
    waitDone(0, 15);

    $display("[TB] test 5: start held high");
    qA.push_back(expANor);
    applyStimulus(0, 1, expANor, 1'b1);
    waitDone(0, 15);
    @(negedge clk);
    check("restart done drops", int'(doneA), 0);
    check("restart busy", int'(busyA), 1);
    check("restart err_count", int'(errA), 0);
    check("restart vec_out", int'(vecA), 0);
    waitDone(0, 15);
    startA = 1'b0;
    @(negedge clk);
    check("held done", int'(doneA), 1);
    check("held busy", int'(busyA), 0);

    repeat (2) @(negedge clk);
    check("queue A drained", qA.size(), 0);
    check("queue B drained", qB.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
